// File: rtl/sdram_arbiter_pkg.sv
// Shared constants and the request bundle used by the SDRAM two-port arbiter.
package sdram_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GNT_A  = 3'd1;
  localparam logic [2:0] ST_GNT_B  = 3'd2;
  localparam logic [2:0] ST_DONE_A = 3'd3;
  localparam logic [2:0] ST_DONE_B = 3'd4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [15:0] TMO_DATA = 16'hFFFF;

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] out;
  } req_t;

endpackage

// File: rtl/sdram_arb_portmux.sv
// Registered 2:1 selection of the request fields; holds them for the whole grant.
module sdram_arb_portmux
  import sdram_arbiter_pkg::*;
(
  input  logic clk_p,
  input  logic rst_n,
  input  logic load,
  input  logic sel_b,
  input  req_t a_req,
  input  req_t b_req,
  output req_t m_req
);

  req_t m_req_q, m_req_d;

  always_comb begin
    m_req_d = m_req_q;
    if (load) begin
      m_req_d = sel_b ? b_req : a_req;
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      m_req_q <= '0;
    end else begin
      m_req_q <= m_req_d;
    end
  end

  assign m_req = m_req_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM transaction port between the processor bus (A) and a DMA master (B),
// with round-robin or fixed priority, a forced idle gap, and an acknowledge timeout.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter bit RR  = 1'b1,
  parameter int TMO = 255
) (
  input  logic        clk_p,
  input  logic        rst_n,
  input  logic        sdram_ready,
  input  logic        a_stb,
  input  logic        a_we,
  input  logic [1:0]  a_sel,
  input  logic [20:0] a_adr,
  input  logic [15:0] a_out,
  output logic [15:0] a_dat,
  output logic        a_ack,
  input  logic        b_stb,
  input  logic        b_we,
  input  logic [1:0]  b_sel,
  input  logic [20:0] b_adr,
  input  logic [15:0] b_out,
  output logic [15:0] b_dat,
  output logic        b_ack,
  output logic        m_stb,
  output logic        m_we,
  output logic [1:0]  m_sel,
  output logic [20:0] m_adr,
  output logic [15:0] m_out,
  input  logic [15:0] m_dat,
  input  logic        m_ack,
  output logic        tmo_err
);

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  logic [2:0]  state_q, state_d;
  logic        m_stb_q, m_stb_d;
  logic        tmo_err_q, tmo_err_d;
  logic        last_q, last_d;
  logic        abort_q, abort_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] a_dat_q, a_dat_d;
  logic [15:0] b_dat_q, b_dat_d;
  logic        grant, win, cur_stb, on_b;
  logic [15:0] rdata;
  req_t        m_req;

  always_comb begin
    state_d   = state_q;
    m_stb_d   = m_stb_q;
    tmo_err_d = 1'b0;
    last_d    = last_q;
    abort_d   = abort_q;
    cnt_d     = cnt_q;
    a_dat_d   = a_dat_q;
    b_dat_d   = b_dat_q;
    grant     = 1'b0;
    on_b      = (state_q == ST_GNT_B) || (state_q == ST_DONE_B);
    cur_stb   = on_b ? b_stb : a_stb;
    rdata     = m_ack ? m_dat : TMO_DATA;
    win       = PORT_A;
    if (b_stb && (!a_stb || (RR && (last_q == PORT_A)))) begin
      win = PORT_B;
    end

    case (state_q)
      ST_IDLE: begin
        if (sdram_ready && (a_stb || b_stb)) begin
          grant   = 1'b1;
          last_d  = win;
          m_stb_d = 1'b1;
          cnt_d   = 8'd0;
          abort_d = 1'b0;
          state_d = (win == PORT_B) ? ST_GNT_B : ST_GNT_A;
        end
      end
      ST_GNT_A, ST_GNT_B: begin
        cnt_d   = cnt_q + 8'd1;
        abort_d = abort_q | ~cur_stb;
        if (m_ack || (cnt_q == TMO_LAST)) begin
          m_stb_d   = 1'b0;
          tmo_err_d = ~m_ack;
          state_d   = on_b ? ST_DONE_B : ST_DONE_A;
          // An aborted requester has gone away; keep its last data untouched.
          if (!abort_d) begin
            if (on_b) b_dat_d = rdata;
            else      a_dat_d = rdata;
          end
        end
      end
      ST_DONE_A, ST_DONE_B: begin
        if (!cur_stb || abort_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_stb_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      last_q    <= PORT_B;
      abort_q   <= 1'b0;
      cnt_q     <= 8'd0;
      a_dat_q   <= 16'd0;
      b_dat_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      m_stb_q   <= m_stb_d;
      tmo_err_q <= tmo_err_d;
      last_q    <= last_d;
      abort_q   <= abort_d;
      cnt_q     <= cnt_d;
      a_dat_q   <= a_dat_d;
      b_dat_q   <= b_dat_d;
    end
  end

  sdram_arb_portmux u_portmux (
    .clk_p (clk_p),
    .rst_n (rst_n),
    .load  (grant),
    .sel_b (win),
    .a_req ('{we: a_we, sel: a_sel, adr: a_adr, out: a_out}),
    .b_req ('{we: b_we, sel: b_sel, adr: b_adr, out: b_out}),
    .m_req (m_req)
  );

  assign m_stb   = m_stb_q;
  assign m_we    = m_req.we;
  assign m_sel   = m_req.sel;
  assign m_adr   = m_req.adr;
  assign m_out   = m_req.out;
  assign tmo_err = tmo_err_q;
  assign a_dat   = a_dat_q;
  assign b_dat   = b_dat_q;
  assign a_ack   = (state_q == ST_DONE_A) && a_stb && !abort_q;
  assign b_ack   = (state_q == ST_DONE_B) && b_stb && !abort_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboarded random bench for sdram_arbiter: request tasks push expected grants,
// a monitor pops and checks them against a rule-level arbitration model.
module tb_sdram_arbiter;

  localparam int TMO = 8;

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] out;
  } txn_t;

  logic        clk_p = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_ready = 1'b0;
  logic        a_stb = 1'b0, a_we = 1'b0;
  logic [1:0]  a_sel = 2'b0;
  logic [20:0] a_adr = 21'd0;
  logic [15:0] a_out = 16'd0;
  logic [15:0] a_dat;
  logic        a_ack;
  logic        b_stb = 1'b0, b_we = 1'b0;
  logic [1:0]  b_sel = 2'b0;
  logic [20:0] b_adr = 21'd0;
  logic [15:0] b_out = 16'd0;
  logic [15:0] b_dat;
  logic        b_ack;
  logic        m_stb, m_we;
  logic [1:0]  m_sel;
  logic [20:0] m_adr;
  logic [15:0] m_out;
  logic [15:0] m_dat = 16'd0;
  logic        m_ack = 1'b0;
  logic        tmo_err;

  int checks = 0;
  int passes = 0;
  txn_t exp_a[$];
  txn_t exp_b[$];
  int   grant_log[$];
  bit   no_ack = 1'b0;
  int   fixed_delay = -1;
  logic [15:0] last_a = 16'd0, last_b = 16'd0;

  sdram_arbiter #(.RR(1'b1), .TMO(TMO)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .sdram_ready(sdram_ready),
    .a_stb(a_stb), .a_we(a_we), .a_sel(a_sel), .a_adr(a_adr), .a_out(a_out),
    .a_dat(a_dat), .a_ack(a_ack),
    .b_stb(b_stb), .b_we(b_we), .b_sel(b_sel), .b_adr(b_adr), .b_out(b_out),
    .b_dat(b_dat), .b_ack(b_ack),
    .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_out(m_out),
    .m_dat(m_dat), .m_ack(m_ack), .tmo_err(tmo_err)
  );

  always #5 clk_p = ~clk_p;

  function automatic logic [15:0] ref_data(input logic [20:0] adr);
    return adr[15:0] ^ {adr[20:16], 11'h2A5};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Downstream model: acknowledges each strobe after a few cycles with address-derived data.
  initial begin
    int d;
    forever begin
      @(posedge clk_p); #1;
      if (!m_stb) m_ack = 1'b0;
      else if (!m_ack && !no_ack) begin
        d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
        repeat (d) begin @(posedge clk_p); #1; end
        if (m_stb) begin
          m_dat = ref_data(m_adr);
          m_ack = 1'b1;
        end
      end
    end
  end

  // Monitor: predicts each grant from the request rules and checks fields, acks and timeouts.
  initial begin
    bit   prev_stb, prev_mack, pa, pb, last_b_win, in_done, prev_exit, aborted, exp_ack, cs;
    int   cur, hi, win;
    txn_t t, ct;
    prev_stb = 0; prev_mack = 0; pa = 0; pb = 0; last_b_win = 1;
    in_done = 0; prev_exit = 0; aborted = 0; cur = -1; hi = 0; ct = '0;
    forever begin
      @(negedge clk_p);
      if (!rst_n) begin
        prev_stb = 0; prev_mack = 0; pa = 0; pb = 0; last_b_win = 1;
        in_done = 0; prev_exit = 0; aborted = 0; cur = -1; hi = 0;
        continue;
      end
      if (prev_exit) in_done = 0;
      if (prev_stb && !m_stb) begin
        in_done = 1;
        check("tmo_err_pulse", tmo_err, !prev_mack);
        if (!prev_mack) check("tmo_cycles", hi, TMO);
      end else begin
        check("tmo_err_quiet", tmo_err, 0);
      end
      if (m_stb && !prev_stb) begin
        check("grant_has_request", pa | pb, 1);
        win = (pa && pb) ? (last_b_win ? 0 : 1) : (pa ? 0 : 1);
        last_b_win = (win == 1);
        cur = win; aborted = 0; hi = 0;
        t = {m_we, m_sel, m_adr, m_out};
        if (win == 0 && exp_a.size() > 0) t = exp_a.pop_front();
        else if (win == 1 && exp_b.size() > 0) t = exp_b.pop_front();
        else check("grant_queue_nonempty", 0, 1);
        check("grant_fields", {m_we, m_sel, m_adr, m_out}, t);
        ct = t;
        grant_log.push_back(win);
      end else if (m_stb) begin
        check("hold_fields", {m_we, m_sel, m_adr, m_out}, ct);
      end
      cs = (cur == 0) ? a_stb : (cur == 1) ? b_stb : 1'b0;
      if (m_stb) begin
        hi++;
        if (!cs) aborted = 1;
      end
      exp_ack = in_done && !aborted && cs;
      check("a_ack", a_ack, (cur == 0) && exp_ack);
      check("b_ack", b_ack, (cur == 1) && exp_ack);
      prev_exit = in_done && (aborted || !cs);
      prev_stb  = m_stb;
      prev_mack = m_ack && m_stb;
      pa = a_stb && sdram_ready;
      pb = b_stb && sdram_ready;
    end
  end

  task automatic req(input bit port, input logic we, input logic [1:0] sel,
                     input logic [20:0] adr, input logic [15:0] out, input bit expect_tmo);
    txn_t t;
    int   n;
    bit   got;
    logic [15:0] want;
    t = '{we: we, sel: sel, adr: adr, out: out};
    want = expect_tmo ? 16'hFFFF : ref_data(adr);
    @(posedge clk_p); #1;
    if (port == 0) begin
      exp_a.push_back(t); a_we = we; a_sel = sel; a_adr = adr; a_out = out; a_stb = 1'b1;
    end else begin
      exp_b.push_back(t); b_we = we; b_sel = sel; b_adr = adr; b_out = out; b_stb = 1'b1;
    end
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk_p);
      got = port ? b_ack : a_ack;
      n++;
    end
    check(port ? "b_ack_seen" : "a_ack_seen", got, 1);
    if (got) begin
      check(port ? "b_dat" : "a_dat", port ? b_dat : a_dat, want);
      if (port) last_b = want; else last_a = want;
    end
    $display("txn port=%s we=%0d sel=%b adr=%h out=%h rdata=%h cycles=%0d",
             port ? "B" : "A", we, sel, adr, out, port ? b_dat : a_dat, n);
    @(posedge clk_p); #1;
    if (port == 0) a_stb = 1'b0; else b_stb = 1'b0;
  endtask

  task automatic wait_m_stb(output bit seen);
    int n;
    seen = 0; n = 0;
    while (n < 50 && !seen) begin
      @(negedge clk_p);
      seen = m_stb;
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic [15:0] held;

    repeat (3) @(posedge clk_p);
    #1;
    check("reset_outputs", {m_stb, m_we, m_sel, m_adr, m_out, tmo_err, a_ack, b_ack}, 0);
    check("reset_dat", {a_dat, b_dat}, 0);
    rst_n = 1'b1;
    sdram_ready = 1'b1;

    fixed_delay = 3;
    req(0, 1'b0, 2'b11, 21'h000100, 16'h0000, 0);
    fixed_delay = -1;
    req(1, 1'b1, 2'b10, 21'h1FFFFF, 16'hA55A, 0);

    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++)
        req(0, 1'($urandom), 2'($urandom), 21'($urandom), 16'($urandom), 0);
      for (int j = 0; j < 4; j++)
        req(1, 1'($urandom), 2'($urandom), 21'($urandom), 16'($urandom), 0);
    join
    check("rr_grant_count", grant_log.size(), 8);
    if (grant_log.size() == 8) begin
      check("rr_first_is_a", grant_log[0], 0);
      for (int k = 1; k < 8; k++) check("rr_alternate", grant_log[k], 1 - grant_log[k-1]);
    end

    no_ack = 1'b1;
    req(0, 1'b0, 2'b11, 21'h0ABCDE, 16'h0000, 1);
    no_ack = 1'b0;

    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk_p);
        req(0, 1'($urandom), 2'($urandom), 21'($urandom), 16'($urandom), 0);
      end
      for (int j = 0; j < 15; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk_p);
        req(1, 1'($urandom), 2'($urandom), 21'($urandom), 16'($urandom), 0);
      end
    join

    // Gating by sdram_ready, then reset in the middle of a grant.
    @(posedge clk_p); #1;
    sdram_ready = 1'b0;
    fixed_delay = 6;
    exp_a.push_back('{we: 1'b0, sel: 2'b01, adr: 21'h000777, out: 16'h0});
    a_we = 1'b0; a_sel = 2'b01; a_adr = 21'h000777; a_out = 16'h0; a_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_p);
      check("gated_no_stb", m_stb, 0);
    end
    @(posedge clk_p); #1;
    sdram_ready = 1'b1;
    wait_m_stb(seen);
    check("grant_after_ready", seen, 1);
    @(posedge clk_p); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stb_ack", {m_stb, a_ack, tmo_err, a_dat}, 0);
    a_stb = 1'b0;
    last_a = 16'd0; last_b = 16'd0;
    @(posedge clk_p); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk_p);
    fixed_delay = 3;

    // Abort: A leaves mid-grant; its data must stay untouched and B proceeds.
    held = last_a;
    @(posedge clk_p); #1;
    exp_a.push_back('{we: 1'b0, sel: 2'b11, adr: 21'h012345, out: 16'h0});
    a_we = 1'b0; a_sel = 2'b11; a_adr = 21'h012345; a_out = 16'h0; a_stb = 1'b1;
    wait_m_stb(seen);
    check("abort_granted", seen, 1);
    @(posedge clk_p); #1;
    a_stb = 1'b0;
    repeat (8) @(negedge clk_p);
    check("abort_dat_kept", a_dat, held);
    fixed_delay = -1;
    req(1, 1'b0, 2'b11, 21'h054321, 16'h0, 0);

    repeat (4) @(posedge clk_p);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
